// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  Module  : pipe_ctrl_pkg
//  Purpose : Shared types and constants for the pipeline front-end sequencer
//            and the hazard logic it shares with the forwarding unit.
//  Contents: state_t        - sequencer state encoding
//            REG_ZERO       - architectural zero register index
//            DEF_CNTW       - default cycle-counter width
//            DEF_DRAIN_CYCLES - default back-end drain length after HALT
//  Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam logic [4:0] REG_ZERO         = 5'd0;
  localparam int         DEF_CNTW         = 16;
  localparam int         DEF_DRAIN_CYCLES = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  Module  : hazard_detect
//  Purpose : Purely combinational load-use hazard compare. Flags when the
//            load currently in EX writes a register that the instruction in
//            ID reads. Writes to the zero register never create a hazard.
//  Ports   : i_ex_mem_read - instruction in EX is a load
//            i_ex_rt       - destination register of that load
//            i_id_rs/rt    - source registers of the instruction in ID
//            o_stall       - load-use hazard present
//  Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rt,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  output logic       o_stall
);

  logic w_dest_live;
  logic w_src_match;

  assign w_dest_live = (i_ex_rt != REG_ZERO);
  assign w_src_match = (i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt);
  assign o_stall     = i_ex_mem_read && w_dest_live && w_src_match;

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  Module  : pipeline_ctrl
//  Purpose : Central sequencer for the 5-stage pipeline front end. Obeys the
//            debug run/step/pause commands, inserts load-use bubbles, applies
//            branch flushes, drains the back end on HALT and counts the
//            cycles in which the pipeline advanced.
//  Ports   : clk, reset         - clock, synchronous active-high reset
//            dbg_run/step/pause - debug unit commands
//            id_rs, id_rt       - sources of the instruction in ID
//            ex_mem_read, ex_rt - load in EX and its destination
//            branch_taken       - branch resolved taken in ID
//            id_halt            - HALT instruction in ID
//            pc_write, ifid_stop, ifid_flush, idex_bubble, pipe_en
//                               - pipeline control strobes (same-cycle)
//            halted             - program finished (registered)
//            cycle_count        - executed-cycle counter (wraps)
//  Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNTW         = DEF_CNTW,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dbg_run,
  input  logic            dbg_step,
  input  logic            dbg_pause,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rt,
  input  logic            branch_taken,
  input  logic            id_halt,
  output logic            pc_write,
  output logic            ifid_stop,
  output logic            ifid_flush,
  output logic            idex_bubble,
  output logic            pipe_en,
  output logic            halted,
  output logic [CNTW-1:0] cycle_count
);

  localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  state_t          r_state;
  logic [DW-1:0]   r_drain;
  logic [CNTW-1:0] r_count;
  logic            r_halted;

  logic w_hazard;
  logic w_pc_write;
  logic w_ifid_stop;
  logic w_ifid_flush;
  logic w_idex_bubble;
  logic w_pipe_en;

  hazard_detect u_hazard (
    .i_ex_mem_read (ex_mem_read),
    .i_ex_rt       (ex_rt),
    .i_id_rs       (id_rs),
    .i_id_rt       (id_rt),
    .o_stall       (w_hazard)
  );

  // Output decode. Reset forces the frozen pattern so the strobes are clean
  // during the reset cycle regardless of the state being left.
  // Inside RUN/STEP the priority is HALT > stall > branch: a HALT is passed
  // on as a NOP rather than bubbled, and a stall suppresses the flush because
  // the branch was resolved on stale operands.
  always_comb begin
    w_pc_write    = 1'b0;
    w_ifid_stop   = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_pipe_en     = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_RUN, ST_STEP: begin
          w_pipe_en = 1'b1;
          if (id_halt) begin
            w_pc_write  = 1'b0;
            w_ifid_stop = 1'b1;
          end else if (w_hazard) begin
            w_pc_write    = 1'b0;
            w_ifid_stop   = 1'b1;
            w_idex_bubble = 1'b1;
          end else begin
            w_pc_write   = 1'b1;
            w_ifid_stop  = 1'b0;
            w_ifid_flush = branch_taken;
          end
        end
        ST_DRAIN: begin
          w_pipe_en     = 1'b1;
          w_idex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sequencer, drain counter and cycle counter. halted is set on the same
  // edge that enters HALTED so it tracks the state with no extra latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_drain  <= '0;
      r_count  <= '0;
      r_halted <= 1'b0;
    end else begin
      if (w_pipe_en) begin
        r_count <= r_count + CNTW'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (dbg_run) begin
            r_state <= ST_RUN;
          end else if (dbg_step) begin
            r_state <= ST_STEP;
          end
        end
        ST_RUN: begin
          if (id_halt) begin
            r_state <= ST_DRAIN;
            r_drain <= DRAIN_LOAD;
          end else if (dbg_pause || !dbg_run) begin
            r_state <= ST_IDLE;
          end
        end
        ST_STEP: begin
          if (id_halt) begin
            r_state <= ST_DRAIN;
            r_drain <= DRAIN_LOAD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (r_drain == '0) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end else begin
            r_drain <= r_drain - DW'(1);
          end
        end
        ST_HALTED: ;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pc_write    = w_pc_write;
  assign ifid_stop   = w_ifid_stop;
  assign ifid_flush  = w_ifid_flush;
  assign idex_bubble = w_idex_bubble;
  assign pipe_en     = w_pipe_en;
  assign halted      = r_halted;
  assign cycle_count = r_count;

endmodule : pipeline_ctrl
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
//  Module  : tb_pipeline_ctrl
//  Purpose : Self-checking bench for pipeline_ctrl. Two instances share one
//            stimulus stream: the default 16-bit counter and a 4-bit counter
//            to exercise wrap. Expected values come from a behavioural model
//            of the sequencer rules.
//  Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       dbg_run, dbg_step, dbg_pause;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       ex_mem_read, branch_taken, id_halt;

  logic        pc_write, ifid_stop, ifid_flush, idex_bubble, pipe_en, halted;
  logic [15:0] cycle_count;
  logic        b_pc_write, b_ifid_stop, b_ifid_flush, b_idex_bubble, b_pipe_en, b_halted;
  logic [3:0]  b_cycle_count;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNTW(16), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .dbg_run(dbg_run), .dbg_step(dbg_step), .dbg_pause(dbg_pause),
    .id_rs(id_rs), .id_rt(id_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .branch_taken(branch_taken), .id_halt(id_halt),
    .pc_write(pc_write), .ifid_stop(ifid_stop), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_en(pipe_en), .halted(halted), .cycle_count(cycle_count)
  );

  pipeline_ctrl #(.CNTW(4), .DRAIN_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .dbg_run(dbg_run), .dbg_step(dbg_step), .dbg_pause(dbg_pause),
    .id_rs(id_rs), .id_rt(id_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .branch_taken(branch_taken), .id_halt(id_halt),
    .pc_write(b_pc_write), .ifid_stop(b_ifid_stop), .ifid_flush(b_ifid_flush),
    .idex_bubble(b_idex_bubble), .pipe_en(b_pipe_en), .halted(b_halted), .cycle_count(b_cycle_count)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: what the pipeline is doing, not how the RTL encodes it.
  bit running;        // free-running under dbg_run
  bit stepping;       // executing a single debug step this cycle
  int drain_left;     // drain cycles still to run, 0 when not draining
  bit m_halted;
  int executed;       // total advanced cycles since reset (unbounded)
  bit valid = 1'b0;   // model known only after the first reset edge

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the model on the edge.
  task automatic tick();
    bit haz, adv, e_pc, e_stop, e_flush, e_bub, e_en;
    #2;
    haz = ex_mem_read && (ex_rt != 0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
    adv = !reset && (running || stepping);
    e_pc = 0; e_stop = 1; e_flush = 0; e_bub = 0; e_en = 0;
    if (adv) begin
      e_en = 1;
      if (id_halt) begin
        e_pc = 0; e_stop = 1;
      end else if (haz) begin
        e_bub = 1;
      end else begin
        e_pc = 1; e_stop = 0; e_flush = branch_taken;
      end
    end else if (!reset && drain_left > 0) begin
      e_en = 1; e_bub = 1;
    end
    if (valid) begin
      chk("pc_write",    {31'd0, pc_write},    {31'd0, e_pc});
      chk("ifid_stop",   {31'd0, ifid_stop},   {31'd0, e_stop});
      chk("ifid_flush",  {31'd0, ifid_flush},  {31'd0, e_flush});
      chk("idex_bubble", {31'd0, idex_bubble}, {31'd0, e_bub});
      chk("pipe_en",     {31'd0, pipe_en},     {31'd0, e_en});
      chk("halted",      {31'd0, halted},      {31'd0, m_halted});
      chk("cycle_count", {16'd0, cycle_count}, executed % 65536);
      chk("cnt4",        {28'd0, b_cycle_count}, executed % 16);
      chk("pipe_en4",    {31'd0, b_pipe_en},   {31'd0, e_en});
    end
    @(posedge clk);
    if (reset) begin
      running = 0; stepping = 0; drain_left = 0; m_halted = 0; executed = 0;
      valid = 1'b1;
    end else begin
      if (e_en) executed++;
      if (m_halted) begin
        // absorbing
      end else if (drain_left > 0) begin
        drain_left--;
        if (drain_left == 0) m_halted = 1;
      end else if (running || stepping) begin
        if (id_halt) begin
          running = 0; stepping = 0; drain_left = 4;
        end else if (stepping) begin
          stepping = 0;
        end else if (dbg_pause || !dbg_run) begin
          running = 0;
        end
      end else begin
        if (dbg_run) running = 1;
        else if (dbg_step) stepping = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic cmd(input bit run, input bit step, input bit pause, input bit halt, input bit br);
    dbg_run = run; dbg_step = step; dbg_pause = pause; id_halt = halt; branch_taken = br;
    tick();
  endtask

  task automatic quiet();
    ex_mem_read = 0; ex_rt = 0; id_rs = 0; id_rt = 0;
  endtask

  task automatic do_reset();
    reset = 1; cmd(0, 0, 0, 0, 0);
    reset = 0;
  endtask

  initial begin
    reset = 1; dbg_run = 0; dbg_step = 0; dbg_pause = 0;
    branch_taken = 0; id_halt = 0; quiet();
    @(negedge clk);
    tick();           // establishes known state
    tick();           // reset cycle checked against the frozen pattern
    reset = 0;

    // Free run, 10 cycles with no hazards (one IDLE cycle to accept run)
    cmd(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cmd(1, 0, 0, 0, 0);
    chk("run10_count", {16'd0, cycle_count}, 32'd10);

    // Load-use hazard, then zero-register load that must not stall
    ex_mem_read = 1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd9;
    cmd(1, 0, 0, 0, 0);
    quiet(); cmd(1, 0, 0, 0, 0);
    ex_mem_read = 1; ex_rt = 5'd0; id_rs = 5'd0;
    cmd(1, 0, 0, 0, 0);
    quiet();

    // Branch alone, then branch with simultaneous stall
    cmd(1, 0, 0, 0, 1);
    ex_mem_read = 1; ex_rt = 5'd7; id_rt = 5'd7;
    cmd(1, 0, 0, 0, 1);
    chk("br_stall_flush", {31'd0, ifid_flush}, 32'd0);
    quiet();

    // Pause back to IDLE, then three spaced single steps
    cmd(1, 0, 1, 0, 0);
    do_reset();
    for (int s = 0; s < 3; s++) begin
      cmd(0, 1, 0, 0, 0);
      cmd(0, 0, 0, 0, 0);
      cmd(0, 0, 0, 0, 0);
    end
    chk("step3_count", {16'd0, cycle_count}, 32'd3);

    // HALT in RUN: drain then halted, dbg_run ignored afterwards
    cmd(1, 0, 0, 0, 0);
    cmd(1, 0, 0, 0, 0);
    cmd(1, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) cmd(1, i[0], 0, 0, 0);
    chk("halted_hold", {31'd0, halted}, 32'd1);

    // Reset pulse in the middle of DRAIN
    do_reset();
    cmd(1, 0, 0, 0, 0);
    cmd(1, 0, 0, 1, 0);
    cmd(1, 0, 0, 0, 0);
    do_reset();
    chk("rst_drain_count", {16'd0, cycle_count}, 32'd0);
    chk("rst_drain_halted", {31'd0, halted}, 32'd0);

    // Counter wrap on the 4-bit instance: 17 run cycles
    cmd(1, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) cmd(1, 0, 0, 0, 0);
    chk("wrap_cnt4", {28'd0, b_cycle_count}, 32'd1);

    // Randomized traffic with occasional resets to escape HALTED
    for (int i = 0; i < 1500; i++) begin
      reset        = ($urandom_range(0, 39) == 0);
      ex_mem_read  = $urandom_range(0, 1) == 1;
      ex_rt        = 5'($urandom_range(0, 3));
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      cmd($urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
          $urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pipeline_ctrl
`default_nettype wire
